// File: rtl/weight_mem_pkg.sv
// Shared types and the saturating add used by the weight store.
package weight_mem_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  // Unsigned weight plus sign-extended delta, clamped to 0..2^data_w-1.
  // Two guard bits above the weight keep both overflow directions visible.
  function automatic logic [31:0] sat_add(input logic [31:0] weight,
                                          input logic [31:0] delta,
                                          input int          data_w);
    logic signed [33:0] sum;
    logic signed [33:0] hi;
    sum = $signed({2'b00, weight}) + $signed({{2{delta[31]}}, delta});
    hi  = (34'sd1 <<< data_w) - 34'sd1;
    if (sum < 34'sd0) return '0;
    if (sum > hi)     return hi[31:0];
    return sum[31:0];
  endfunction

endpackage

// File: rtl/weight_sat_add.sv
// Combinational clamp adder for the update stage: weight + signed delta.
module weight_sat_add
  import weight_mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DELTA_W = 4
) (
  input  logic [DATA_W-1:0]  weight,
  input  logic [DELTA_W-1:0] delta,
  output logic [DATA_W-1:0]  result
);

  logic [31:0] w_ext;
  logic [31:0] d_ext;

  assign w_ext  = 32'(weight);
  assign d_ext  = {{(32-DELTA_W){delta[DELTA_W-1]}}, delta};
  assign result = DATA_W'(sat_add(w_ext, d_ext, DATA_W));

endmodule

// File: rtl/weight_mem.sv
// Synaptic weight store: host write, registered read, 2-stage saturating update.
// Optional background clear sequencer enabled by WMEM_CLEAR_EN.
module weight_mem
  import weight_mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int DELTA_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  input  logic               upd_en,
  input  logic [ADDR_W-1:0]  upd_addr,
  input  logic [DELTA_W-1:0] upd_delta,
`ifdef WMEM_CLEAR_EN
  input  logic               clr_req,
`endif
  output logic               busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  logic               wr_ok, upd_ok, u1_we, clr_we;
  logic [ADDR_W-1:0]  clr_addr;
  logic               u0_valid;
  logic [ADDR_W-1:0]  u0_addr;
  logic [DELTA_W-1:0] u0_delta;
  logic [DATA_W-1:0]  u1_base, u1_result;
  logic               fwd_valid;
  logic [ADDR_W-1:0]  fwd_addr;
  logic [DATA_W-1:0]  fwd_data;

`ifdef WMEM_CLEAR_EN
  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: if (cnt == ADDR_W'(DEPTH-1)) state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign wr_ok  = wr_en  & ~busy & in_range(wr_addr);
  assign upd_ok = upd_en & ~busy & in_range(upd_addr);
  // A sweep discards whatever the update pipe was carrying.
  assign u1_we  = u0_valid & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u0_valid <= 1'b0;
      u0_addr  <= '0;
      u0_delta <= '0;
    end else begin
      u0_valid <= upd_ok;
      if (upd_ok) begin
        u0_addr  <= upd_addr;
        u0_delta <= upd_delta;
      end
    end
  end

  assign u1_base = (fwd_valid && fwd_addr == u0_addr) ? fwd_data : mem[u0_addr];

  weight_sat_add #(.DATA_W(DATA_W), .DELTA_W(DELTA_W)) u_sat (
    .weight (u1_base),
    .delta  (u0_delta),
    .result (u1_result)
  );

  // Forwarded value is whatever actually landed in the array, so a colliding
  // host write replaces the update result here too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= u1_we;
      fwd_addr  <= u0_addr;
      fwd_data  <= (wr_ok && wr_addr == u0_addr) ? wr_data : u1_result;
    end
  end

  // Host write is assigned last so it wins over a same-address writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (u1_we) mem[u0_addr] <= u1_result;
      if (wr_ok) mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= in_range(rd_addr) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_weight_mem.sv
// Scoreboard bench for weight_mem: driver queues expected reads, monitor checks them.
module tb_weight_mem;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int DELTA_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               wr_en = 1'b0;
  logic [ADDR_W-1:0]  wr_addr = '0;
  logic [DATA_W-1:0]  wr_data = '0;
  logic               rd_en = 1'b0;
  logic [ADDR_W-1:0]  rd_addr = '0;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_valid;
  logic               upd_en = 1'b0;
  logic [ADDR_W-1:0]  upd_addr = '0;
  logic [DELTA_W-1:0] upd_delta = '0;
  logic               clr_req = 1'b0;
  logic               busy;

  weight_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DELTA_W(DELTA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .upd_en    (upd_en),
    .upd_addr  (upd_addr),
    .upd_delta (upd_delta),
`ifdef WMEM_CLEAR_EN
    .clr_req   (clr_req),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding read.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rd_valid: got rd_data %0h with no read outstanding", rd_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rd_data[%0d]", e.addr), 32'(rd_data), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back('{addr: a, data: e});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_upd(input logic [ADDR_W-1:0] a, input logic [DELTA_W-1:0] d);
    upd_en = 1'b1; upd_addr = a; upd_delta = d;
    tick();
    upd_en = 1'b0;
  endtask

  initial begin
    int n;
    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data",  32'(rd_data),  32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) do_rd(ADDR_W'(i), 8'h00);

    // Write then read, and read-first on a same-cycle write
    do_wr(4'd3, 8'hA5);
    do_rd(4'd3, 8'hA5);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h5A;
    rd_en = 1'b1; rd_addr = 4'd3;
    exp_q.push_back('{addr: 4'd3, data: 8'hA5});
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    do_rd(4'd3, 8'h5A);

    // Saturation both ways plus an in-range decrement; read at update+2
    do_wr(4'd5, 8'd250);
    do_upd(4'd5, 4'h7);
    tick();
    do_rd(4'd5, 8'd255);
    do_wr(4'd6, 8'd3);
    do_upd(4'd6, 4'h8);
    tick();
    do_rd(4'd6, 8'd0);
    do_wr(4'd7, 8'd200);
    do_upd(4'd7, 4'hF);
    tick();
    do_rd(4'd7, 8'd199);

    // Back-to-back updates accumulate
    do_wr(4'd2, 8'd100);
    do_upd(4'd2, 4'h5);
    do_upd(4'd2, 4'h5);
    do_upd(4'd2, 4'h5);
    tick();
    do_rd(4'd2, 8'd115);

    // Host write collides with writeback; following update builds on the host value
    do_upd(4'd2, 4'h5);
    upd_en = 1'b1; upd_addr = 4'd2; upd_delta = 4'h5;
    wr_en  = 1'b1; wr_addr  = 4'd2; wr_data   = 8'h40;
    tick();
    upd_en = 1'b0; wr_en = 1'b0;
    do_rd(4'd2, 8'h40);
    do_rd(4'd2, 8'h45);

`ifdef WMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) do_wr(ADDR_W'(i), 8'(i + 16));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy_start", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      wr_en = (n == 0); wr_addr = 4'd15; wr_data = 8'h77;
      tick();
      n++;
    end
    wr_en = 1'b0;
    check("clr_busy_cycles", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) do_rd(ADDR_W'(i), 8'h00);
`endif

    // Reset mid-operation with an update in flight (and a clear starting)
    do_wr(4'd4, 8'h33);
    do_rd(4'd4, 8'h33);
    upd_en = 1'b1; upd_addr = 4'd4; upd_delta = 4'h3;
    clr_req = 1'b1;
    tick();
    upd_en = 1'b0; clr_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy",    32'(busy),    32'd0);
    check("midreset_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) do_rd(ADDR_W'(i), 8'h00);

    repeat (3) tick();
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/weight_mem.md
# weight_mem

Parametrised synaptic weight store for the reward-modulated SNN core; successor to the fixed 16x8 register memory. Provides a host write port, a registered read port, and a two-stage read-modify-write update port that applies signed reward deltas to stored weights with saturation. An optional sequencer clears the whole array in the background.

## Interface
Parameters:
- DATA_W, 8, weight width; unsigned weight range 0..2^DATA_W-1
- DEPTH, 16, number of entries; any value of 2 or more
- ADDR_W, $clog2(DEPTH), address width
- DELTA_W, 4, width of the signed two's-complement update delta

Ports:
- clk  in  1  clock; all logic is posedge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  host write strobe
- wr_addr  in  ADDR_W  host write address
- wr_data  in  DATA_W  host write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data is valid this cycle
- upd_en  in  1  reward update strobe
- upd_addr  in  ADDR_W  update target
- upd_delta  in  DELTA_W  signed delta
- clr_req  in  1  start a bulk clear; present only with WMEM_CLEAR_EN
- busy  out  1  bulk clear in progress

## Operation
- Reset:
  - All entries are cleared to 0.
  - rd_data is 0, rd_valid is 0 and busy is 0.
  - The update pipeline is emptied, and any clear in progress is aborted.
- Host write: when wr_en is high, mem[wr_addr] takes wr_data at the clock edge.
- Read: when rd_en is high, the next cycle has rd_data = mem[rd_addr] and rd_valid = 1.
  - Reads are read-first: a write to the same address in the same cycle is not visible.
  - When rd_en is low, rd_valid = 0 and rd_data holds its last value.
- Update stage U0: when upd_en is high, capture upd_addr and upd_delta and set u0_valid.
- Update stage U1: result = clamp(mem[addr] + sext(delta), 0, 2^DATA_W-1), computed at DATA_W+2 bits signed. The result is written at the end of U1.
- Update forwarding: if the U1 write and a new U1 target the same address on consecutive updates, the new U1 uses the forwarded U1 result instead of the array value. Back-to-back updates to one address therefore accumulate correctly.
- Address collision: if a U1 writeback and wr_en target the same address in the same cycle, the host write wins and the update is dropped. The forwarding path must also carry wr_data in that case.
- Out-of-range address (address >= DEPTH when DEPTH is not a power of 2): writes and updates are ignored, and reads return 0 with rd_valid = 1.
- Updates are accepted every cycle; there is no backpressure.

## Timing
- Read latency: 1 cycle.
- Update latency: upd_en at edge N is visible to a read issued at edge N+2, with data at N+3.
- Host write latency: wr_en at edge N is visible to a read issued at edge N+1.
- Reset takes effect immediately, with no clock required. Release is synchronous to the next clk edge.

## Configuration
- Macro: WMEM_CLEAR_EN.
- Defined:
  - The clr_req port exists, with a two-state FSM, IDLE and CLEAR.
  - In IDLE, clr_req moves the FSM to CLEAR, with the sweep counter at 0 and busy = 1 on the next cycle.
  - CLEAR writes 0 to entry cnt each cycle. It returns to IDLE after entry DEPTH-1, so busy is high for exactly DEPTH cycles.
  - While busy, wr_en, upd_en and clr_req are ignored, and updates already in U0/U1 are discarded. Reads proceed normally and return the partially cleared contents.
- Not defined: there is no clr_req port, busy is tied to 0, and no FSM is present.

## Structure
- Package weight_mem_pkg holds the FSM state enum (IDLE, CLEAR) and a sat_add function, parametrised through its arguments.
- Sub-module weight_sat_add is the combinational clamp adder (DATA_W, DELTA_W) used by U1.
- Memory array, read register, update pipeline and clear FSM live in weight_mem.

## Test plan
- Reset: after reset, read addresses 0..15 -> rd_data 0 and rd_valid 1 one cycle after each rd_en.
- Write/read:
  - Write 0xA5 to address 3 then read address 3 -> 0xA5 after 1 cycle.
  - Write and read address 3 in the same cycle -> the read returns the old value.
- Saturation:
  - mem[5]=250 with delta +7 (DATA_W=8, DELTA_W=4) -> 255.
  - mem[6]=3 with delta -8 -> 0.
- Forwarding: mem[2]=100 with three consecutive updates of +5 to address 2 -> 115. A collision check writing 0x40 via wr_en together with the U1 writeback to 2 -> 0x40.
- Clear (WMEM_CLEAR_EN): fill the array, pulse clr_req -> busy high for 16 cycles, wr_en ignored during the sweep, then all entries 0.
- Reset mid-operation: assert rst_n low during a clear and an active update -> busy 0 immediately, all entries 0, and no stale writeback after release.
